// File: rtl/soc_bus_pkg.sv
// Shared types and helpers for the SoC memory-mapped fabric.
// Holds the FSM encoding, the fault counter width and a packed-vector slice helper.
package soc_bus_pkg;

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        ACTIVE = 2'd1,
        ERR    = 2'd2
    } state_e;

    localparam int FAULT_CNT_W = 16;
    localparam int SLICE_MAX_W = 64;
    localparam int PACK_MAX_W  = 16 * SLICE_MAX_W;

    // Callers zero-extend their packed vector to PACK_MAX_W and truncate the result to W.
    function automatic logic [SLICE_MAX_W-1:0] slave_slice(
        input logic [PACK_MAX_W-1:0] packed_v,
        input int unsigned           i,
        input int unsigned           w
    );
        logic [PACK_MAX_W-1:0]  shifted;
        logic [SLICE_MAX_W-1:0] mask;
        shifted = packed_v >> (i * w);
        mask    = (w >= SLICE_MAX_W) ? '1 : ((SLICE_MAX_W'(1) << w) - SLICE_MAX_W'(1));
        return shifted[SLICE_MAX_W-1:0] & mask;
    endfunction

endpackage

// File: rtl/soc_bus_decoder.sv
// Combinational address decoder: compares the address against every base/mask pair
// and reports a hit plus the index of the lowest-numbered matching slave.
module soc_bus_decoder
    import soc_bus_pkg::*;
#(
    parameter int                           NUM_SLAVES = 8,
    parameter int                           ADDR_W     = 32,
    parameter int                           IDX_W      = 3,
    parameter logic [NUM_SLAVES*ADDR_W-1:0] SLAVE_BASE = '0,
    parameter logic [NUM_SLAVES*ADDR_W-1:0] SLAVE_MASK = '0
) (
    input  logic [ADDR_W-1:0] addr,
    output logic              hit,
    output logic [IDX_W-1:0]  idx
);

    // Scanning from the top down lets the lowest matching index overwrite the others.
    always_comb begin
        hit = 1'b0;
        idx = '0;
        for (int i = NUM_SLAVES - 1; i >= 0; i--) begin
            if ((addr & ADDR_W'(slave_slice(PACK_MAX_W'(SLAVE_MASK), i, ADDR_W)))
                    == ADDR_W'(slave_slice(PACK_MAX_W'(SLAVE_BASE), i, ADDR_W))) begin
                hit = 1'b1;
                idx = IDX_W'(i);
            end
        end
    end

endmodule

// File: rtl/soc_bus_fabric.sv
// Single-outstanding memory-mapped interconnect from the CPU master port to NUM_SLAVES
// peripherals, with decode-miss and timeout faulting plus fault diagnostics registers.
module soc_bus_fabric
    import soc_bus_pkg::*;
#(
    parameter int                           NUM_SLAVES     = 8,
    parameter int                           ADDR_W         = 32,
    parameter int                           DATA_W         = 32,
    parameter logic [NUM_SLAVES*ADDR_W-1:0] SLAVE_BASE     = '0,
    parameter logic [NUM_SLAVES*ADDR_W-1:0] SLAVE_MASK     = '0,
    parameter int unsigned                  TIMEOUT_CYCLES = 1024,
    parameter logic [DATA_W-1:0]            DEFAULT_RDATA  = '0
) (
    input  logic                         clk,
    input  logic                         resetn,
    input  logic                         m_valid,
    input  logic [ADDR_W-1:0]            m_addr,
    input  logic [DATA_W/8-1:0]          m_wstrb,
    input  logic [DATA_W-1:0]            m_wdata,
    output logic                         m_ready,
    output logic [DATA_W-1:0]            m_rdata,
    output logic                         m_fault,
    output logic [NUM_SLAVES-1:0]        s_valid,
    output logic [ADDR_W-1:0]            s_addr,
    output logic [DATA_W/8-1:0]          s_wstrb,
    output logic [DATA_W-1:0]            s_wdata,
    input  logic [NUM_SLAVES-1:0]        s_ready,
    input  logic [NUM_SLAVES*DATA_W-1:0] s_rdata,
    output logic [FAULT_CNT_W-1:0]       fault_count,
    output logic [ADDR_W-1:0]            last_fault_addr
);

    localparam int          STRB_W  = DATA_W / 8;
    localparam int          IDX_W   = (NUM_SLAVES > 1) ? $clog2(NUM_SLAVES) : 1;
    localparam logic [31:0] TO_LAST = 32'(TIMEOUT_CYCLES - 1);

    state_e                 state_q, state_d;
    logic [IDX_W-1:0]       sel_q, sel_d;
    logic [ADDR_W-1:0]      addr_q, addr_d;
    logic [STRB_W-1:0]      wstrb_q, wstrb_d;
    logic [DATA_W-1:0]      wdata_q, wdata_d;
    logic [31:0]            cnt_q, cnt_d;
    logic [FAULT_CNT_W-1:0] fault_count_q, fault_count_d;
    logic [ADDR_W-1:0]      last_fault_addr_q, last_fault_addr_d;

    logic                   dec_hit;
    logic [IDX_W-1:0]       dec_idx;
    logic                   sel_ready;

    soc_bus_decoder #(
        .NUM_SLAVES (NUM_SLAVES),
        .ADDR_W     (ADDR_W),
        .IDX_W      (IDX_W),
        .SLAVE_BASE (SLAVE_BASE),
        .SLAVE_MASK (SLAVE_MASK)
    ) u_decoder (
        .addr (m_addr),
        .hit  (dec_hit),
        .idx  (dec_idx)
    );

    assign sel_ready       = s_ready[sel_q];
    assign s_addr          = addr_q;
    assign s_wstrb         = wstrb_q;
    assign s_wdata         = wdata_q;
    assign fault_count     = fault_count_q;
    assign last_fault_addr = last_fault_addr_q;

    always_comb begin
        state_d           = state_q;
        sel_d             = sel_q;
        addr_d            = addr_q;
        wstrb_d           = wstrb_q;
        wdata_d           = wdata_q;
        cnt_d             = cnt_q;
        fault_count_d     = fault_count_q;
        last_fault_addr_d = last_fault_addr_q;
        m_ready           = 1'b0;
        m_fault           = 1'b0;
        m_rdata           = '0;
        s_valid           = '0;

        unique case (state_q)
            IDLE: begin
                if (m_valid) begin
                    addr_d  = m_addr;
                    wstrb_d = m_wstrb;
                    wdata_d = m_wdata;
                    sel_d   = dec_idx;
                    cnt_d   = '0;
                    state_d = dec_hit ? ACTIVE : ERR;
                end
            end
            ACTIVE: begin
                s_valid[sel_q] = 1'b1;
                cnt_d          = cnt_q + 32'd1;
                // A ready arriving in the expiry cycle still completes the access cleanly.
                if (sel_ready) begin
                    m_ready = 1'b1;
                    m_rdata = DATA_W'(slave_slice(PACK_MAX_W'(s_rdata), 32'(sel_q), DATA_W));
                    state_d = IDLE;
                end else if ((TIMEOUT_CYCLES != 0) && (cnt_q == TO_LAST)) begin
                    state_d = ERR;
                end
            end
            ERR: begin
                m_ready           = 1'b1;
                m_fault           = 1'b1;
                m_rdata           = DEFAULT_RDATA;
                last_fault_addr_d = addr_q;
                if (fault_count_q != '1) begin
                    fault_count_d = fault_count_q + FAULT_CNT_W'(1);
                end
                state_d = IDLE;
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            state_q           <= IDLE;
            sel_q             <= '0;
            addr_q            <= '0;
            wstrb_q           <= '0;
            wdata_q           <= '0;
            cnt_q             <= '0;
            fault_count_q     <= '0;
            last_fault_addr_q <= '0;
        end else begin
            state_q           <= state_d;
            sel_q             <= sel_d;
            addr_q            <= addr_d;
            wstrb_q           <= wstrb_d;
            wdata_q           <= wdata_d;
            cnt_q             <= cnt_d;
            fault_count_q     <= fault_count_d;
            last_fault_addr_q <= last_fault_addr_d;
        end
    end

endmodule

// File: tb/tb_soc_bus_fabric.sv
// Bench for soc_bus_fabric: directed scenarios followed by randomized transactions,
// each checked against an address-map and transaction-outcome reference model.
module tb_soc_bus_fabric;

    localparam int NS = 8;
    localparam int AW = 32;
    localparam int DW = 32;
    localparam int SW = DW / 8;
    localparam int T  = 8;

    localparam logic [NS*AW-1:0] BASE = {
        32'h7000_0000, 32'h6000_0000, 32'h4000_0000, 32'h1200_0000,
        32'h2100_0000, 32'h1000_0000, 32'h3000_0000, 32'h2000_0000};
    localparam logic [NS*AW-1:0] MASK = {
        32'hFFF0_0000, 32'hF000_0000, 32'hFFFF_0000, 32'hFF00_0000,
        32'hFF00_0000, 32'hFF00_0000, 32'hFF00_0000, 32'hF000_0000};

    logic [31:0] map_base [NS] = '{32'h2000_0000, 32'h3000_0000, 32'h1000_0000, 32'h2100_0000,
                                   32'h1200_0000, 32'h4000_0000, 32'h6000_0000, 32'h7000_0000};
    logic [31:0] map_mask [NS] = '{32'hF000_0000, 32'hFF00_0000, 32'hFF00_0000, 32'hFF00_0000,
                                   32'hFF00_0000, 32'hFFFF_0000, 32'hF000_0000, 32'hFFF0_0000};

    logic              clk;
    logic              resetn;
    logic              m_valid;
    logic [AW-1:0]     m_addr;
    logic [SW-1:0]     m_wstrb;
    logic [DW-1:0]     m_wdata;
    logic              m_ready;
    logic [DW-1:0]     m_rdata;
    logic              m_fault;
    logic [NS-1:0]     s_valid;
    logic [AW-1:0]     s_addr;
    logic [SW-1:0]     s_wstrb;
    logic [DW-1:0]     s_wdata;
    logic [NS-1:0]     s_ready;
    logic [NS*DW-1:0]  s_rdata;
    logic [15:0]       fault_count;
    logic [AW-1:0]     last_fault_addr;

    int          n_tests = 0;
    int          n_fail  = 0;
    logic [15:0] mdl_fault_count = '0;
    logic [31:0] mdl_last_addr   = '0;

    soc_bus_fabric #(
        .NUM_SLAVES     (NS),
        .ADDR_W         (AW),
        .DATA_W         (DW),
        .SLAVE_BASE     (BASE),
        .SLAVE_MASK     (MASK),
        .TIMEOUT_CYCLES (T),
        .DEFAULT_RDATA  (32'h0000_0000)
    ) dut (
        .clk             (clk),
        .resetn          (resetn),
        .m_valid         (m_valid),
        .m_addr          (m_addr),
        .m_wstrb         (m_wstrb),
        .m_wdata         (m_wdata),
        .m_ready         (m_ready),
        .m_rdata         (m_rdata),
        .m_fault         (m_fault),
        .s_valid         (s_valid),
        .s_addr          (s_addr),
        .s_wstrb         (s_wstrb),
        .s_wdata         (s_wdata),
        .s_ready         (s_ready),
        .s_rdata         (s_rdata),
        .fault_count     (fault_count),
        .last_fault_addr (last_fault_addr)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_tests++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: got %0h expected %0h", tag, obs, exp);
        end
    endtask

    function automatic int ref_decode(input logic [31:0] addr);
        for (int i = 0; i < NS; i++) begin
            if ((addr & map_mask[i]) == map_base[i]) return i;
        end
        return -1;
    endfunction

    // rdly: ACTIVE cycle (0-based) in which the selected slave readies; -1 means never.
    task automatic run_txn(input logic [31:0] addr, input logic [3:0] strb, input logic [31:0] wdata,
                           input int rdly, input logic [31:0] rdata, input bit drop_valid);
        int          sel;
        int          done;
        bit          fault;
        logic [NS-1:0] rdy;
        logic [NS-1:0] exp_sv;
        sel = ref_decode(addr);
        if (sel < 0) begin
            done  = 0;
            fault = 1'b1;
        end else if (rdly >= 0 && rdly < T) begin
            done  = rdly;
            fault = 1'b0;
        end else begin
            done  = T;
            fault = 1'b1;
        end
        @(negedge clk);
        m_valid = 1'b1;
        m_addr  = addr;
        m_wstrb = strb;
        m_wdata = wdata;
        s_ready = NS'($urandom);
        #1;
        chk("idle_m_ready", 32'(m_ready), 32'(0));
        chk("idle_s_valid", 32'(s_valid), 32'(0));
        chk("fault_count", 32'(fault_count), 32'(mdl_fault_count));
        chk("last_fault_addr", last_fault_addr, mdl_last_addr);
        for (int c = 0; c <= done; c++) begin
            @(negedge clk);
            if (drop_valid) m_valid = 1'b0;
            rdy = NS'($urandom) | NS'(8'h20);
            if (sel >= 0) rdy[sel] = (!fault && c == done);
            s_ready = rdy;
            for (int k = 0; k < NS; k++) s_rdata[k*DW +: DW] = (sel == k) ? rdata : $urandom;
            #1;
            exp_sv = '0;
            if (sel >= 0 && !(fault && c == done)) exp_sv[sel] = 1'b1;
            chk("s_valid", 32'(s_valid), 32'(exp_sv));
            chk("m_ready", 32'(m_ready), 32'(c == done));
            if (c == 0 && sel >= 0) begin
                chk("s_addr", s_addr, addr);
                chk("s_wstrb", 32'(s_wstrb), 32'(strb));
                chk("s_wdata", s_wdata, wdata);
            end
            if (c == done) begin
                chk("m_fault", 32'(m_fault), 32'(fault));
                chk("m_rdata", m_rdata, fault ? 32'h0 : rdata);
            end
        end
        m_valid = 1'b0;
        if (fault) begin
            if (mdl_fault_count != 16'hFFFF) mdl_fault_count = mdl_fault_count + 16'd1;
            mdl_last_addr = addr;
        end
    endtask

    initial begin
        resetn  = 1'b0;
        m_valid = 1'b0;
        m_addr  = '0;
        m_wstrb = '0;
        m_wdata = '0;
        s_ready = '0;
        s_rdata = '0;
        repeat (3) @(negedge clk);
        #1;
        chk("rst_s_valid", 32'(s_valid), 32'(0));
        chk("rst_m_ready", 32'(m_ready), 32'(0));
        chk("rst_m_fault", 32'(m_fault), 32'(0));
        chk("rst_m_rdata", m_rdata, 32'h0);
        chk("rst_s_addr", s_addr, 32'h0);
        chk("rst_fault_count", 32'(fault_count), 32'(0));
        chk("rst_last_fault", last_fault_addr, 32'h0);
        @(negedge clk);
        resetn = 1'b1;

        // Directed scenarios
        run_txn(32'h1000_0004, 4'h0, 32'h0, 3, 32'hDEAD_BEEF, 1'b0);
        run_txn(32'h1200_0000, 4'hF, 32'h0000_00A5, 0, 32'h1234_5678, 1'b0);
        run_txn(32'h5000_0000, 4'h0, 32'h0, 0, 32'h0, 1'b0);
        run_txn(32'h3000_0000, 4'h0, 32'h0, -1, 32'h0, 1'b0);
        run_txn(32'h3000_0040, 4'h3, 32'h55AA_55AA, T - 1, 32'hCAFE_F00D, 1'b0);
        run_txn(32'h2100_0010, 4'h0, 32'h0, 2, 32'h0BAD_CAFE, 1'b0);
        run_txn(32'h4000_1230, 4'h1, 32'h0000_0077, 1, 32'h8765_4321, 1'b1);
        run_txn(32'h7000_0000, 4'h0, 32'h0, 4, 32'h7777_0000, 1'b1);

        // Randomized transactions
        for (int n = 0; n < 40; n++) begin
            int          r;
            logic [31:0] a;
            r = int'($urandom_range(0, 9));
            if (r < NS) a = map_base[r] | ($urandom & ~map_mask[r]);
            else        a = $urandom;
            run_txn(a, 4'($urandom), $urandom, int'($urandom_range(0, 10)) - 1,
                    $urandom, ($urandom_range(0, 3) == 0));
        end

        // Asynchronous reset in the middle of an access
        @(negedge clk);
        m_valid = 1'b1;
        m_addr  = 32'h3000_0010;
        m_wstrb = 4'hF;
        m_wdata = 32'hFFFF_FFFF;
        s_ready = '0;
        @(negedge clk);
        #1;
        chk("pre_rst_s_valid", 32'(s_valid), 32'(8'h02));
        resetn  = 1'b0;
        s_ready = 8'h02;
        #1;
        chk("mid_rst_s_valid", 32'(s_valid), 32'(0));
        chk("mid_rst_m_ready", 32'(m_ready), 32'(0));
        chk("mid_rst_s_addr", s_addr, 32'h0);
        chk("mid_rst_s_wstrb", 32'(s_wstrb), 32'(0));
        chk("mid_rst_s_wdata", s_wdata, 32'h0);
        chk("mid_rst_fault_count", 32'(fault_count), 32'(0));
        chk("mid_rst_last_fault", last_fault_addr, 32'h0);
        mdl_fault_count = '0;
        mdl_last_addr   = '0;
        m_valid = 1'b0;
        @(negedge clk);
        resetn = 1'b1;
        @(negedge clk);
        #1;
        chk("post_rst_m_ready", 32'(m_ready), 32'(0));
        chk("post_rst_s_valid", 32'(s_valid), 32'(0));

        // Preload the fault counter near its ceiling, then drive it into saturation
        @(negedge clk);
        force dut.fault_count_q = 16'hFFFD;
        @(negedge clk);
        release dut.fault_count_q;
        mdl_fault_count = 16'hFFFD;
        for (int n = 0; n < 4; n++) begin
            run_txn(32'h8000_0000 + 32'(n * 4), 4'h0, 32'h0, 0, 32'h0, 1'b0);
        end
        @(negedge clk);
        #1;
        chk("sat_fault_count", 32'(fault_count), 32'(mdl_fault_count));
        chk("sat_last_fault", last_fault_addr, mdl_last_addr);
        chk("final_m_ready", 32'(m_ready), 32'(0));

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
